jogador_automatico: RTL and testbench
=====================================

JOGADOR_AUTOMATICO -- requirements
Module: jogador_automatico

Interface
REQ-001 SHALL provide parameter HOLD, 100, cycles a button is held during replay (>=1).
REQ-002 SHALL provide parameter GAP, 100, cycles of release between presses (>=1).
REQ-003 SHALL provide parameter QUIET, 1000, idle-LED cycles that end the observation phase (>=2).
REQ-004 SHALL provide parameter PULSO_INI, 5, cycles iniciar is held high.
REQ-005 SHALL provide parameter RODADA_ERRO, 0, replay round (1-based) whose final press is withheld to force a game timeout; 0 disables injection.
REQ-006 SHALL have port clock  input  1  single system clock, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port habilitar  input  1  enables the automatic player.
REQ-009 SHALL have port leds  input  4  LED pattern shown by the game.
REQ-010 SHALL have port ganhou  input  1  game-won indication.
REQ-011 SHALL have port perdeu  input  1  game-lost indication.
REQ-012 SHALL have port iniciar  output  1  start request to the game.
REQ-013 SHALL have port botoes  output  4  one-hot button drive to the game.
REQ-014 SHALL have port erro  output  1  sticky flag: invalid LED pattern or capture overflow.
REQ-015 SHALL have port db_estado  output  4  current FSM state code.
REQ-016 SHALL have port db_contagem  output  5  number of captured plays (0-16).

Function
REQ-017 SHALL implement states INICIAL=0, PULSO=1, OBSERVA=2, PRESSIONA=3, SOLTA=4, FIM=6; all outputs registered.
REQ-018 SHALL in INICIAL drive iniciar=0, botoes=0; on habilitar rising edge (sampled 0 then 1) go to PULSO.
REQ-019 SHALL in PULSO drive iniciar=1 for exactly PULSO_INI cycles, then go to OBSERVA with count=0, round=0.
REQ-020 SHALL in OBSERVA detect a capture on leds!=0 while the registered previous leds==0; capture writes leds into 16x4 memory at address count, count+1.
REQ-021 SHALL treat a captured value that is not one-hot as invalid: not stored, erro set.
REQ-022 SHALL ignore a valid capture when count==16 and set erro; count saturates at 16.
REQ-023 SHALL run a quiet counter in OBSERVA only while count>0 and leds==0; any nonzero leds clears it.
REQ-024 SHALL on quiet counter reaching QUIET go to PRESSIONA with ptr=0 and round+1 (round saturates at 15).
REQ-025 SHALL in PRESSIONA drive botoes=mem[ptr] for exactly HOLD cycles, then go to SOLTA.
REQ-026 SHALL when round==RODADA_ERRO and ptr==count-1 drive botoes=0 for that PRESSIONA slot.
REQ-027 SHALL in SOLTA drive botoes=0 for exactly GAP cycles, then ptr+1; if new ptr==count clear count and return to OBSERVA, else PRESSIONA.
REQ-028 SHALL go to FIM from PULSO, OBSERVA, PRESSIONA or SOLTA on ganhou=1 or perdeu=1 within one cycle; botoes=0, iniciar=0 in FIM.
REQ-029 SHALL leave FIM to INICIAL only when habilitar=0.
REQ-030 SHALL on habilitar=0 in any state other than FIM return to INICIAL next cycle with botoes=0, iniciar=0, count=0.
REQ-031 SHALL hold erro until reset; erro does not alter FSM flow.

Reset
REQ-032 SHALL on reset=1 asynchronously force state INICIAL, iniciar=0, botoes=0, erro=0, count=0, ptr=0, round=0, all timers 0; memory contents undefined.
REQ-033 SHALL abandon any replay in progress on reset with botoes=0 the same instant.

Verification (HOLD=4, GAP=4, QUIET=20, PULSO_INI=5)
REQ-034 SHALL cover start: reset, habilitar 0->1 -> iniciar=1 for exactly 5 cycles, db_estado 1 then 2.
REQ-035 SHALL cover replay: leds pulses 0001,0010,0100 then 20 idle cycles -> botoes 0001,0010,0100 each 4 cycles separated by 4 cycles of 0000, db_contagem returns 0.
REQ-036 SHALL cover injection: RODADA_ERRO=3, rounds of 1,2,3 plays -> round 3 drives only first two presses, third slot 0000.
REQ-037 SHALL cover errors: leds=0011 -> erro=1, db_contagem unchanged; 17 valid pulses -> db_contagem=16, erro=1.
REQ-038 SHALL cover termination: perdeu=1 mid-PRESSIONA -> botoes=0000, db_estado=6 next cycle; habilitar=0 -> db_estado=0.
REQ-039 SHALL cover reset mid-SOLTA: reset asserted -> botoes=0, db_estado=0, db_contagem=0 without clock edge.

Source files
------------

// File: rtl/jogador_automatico.sv
// jogador_automatico: watches the game's LED sequence, then replays it on the buttons each round
module jogador_automatico #(
  parameter int HOLD        = 100,
  parameter int GAP         = 100,
  parameter int QUIET       = 1000,
  parameter int PULSO_INI   = 5,
  parameter int RODADA_ERRO = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilitar,
  input  logic [3:0] leds,
  input  logic       ganhou,
  input  logic       perdeu,
  output logic       iniciar,
  output logic [3:0] botoes,
  output logic       erro,
  output logic [3:0] db_estado,
  output logic [4:0] db_contagem
);
  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    PULSO     = 4'd1,
    OBSERVA   = 4'd2,
    PRESSIONA = 4'd3,
    SOLTA     = 4'd4,
    FIM       = 4'd6
  } estado_t;
  localparam logic [15:0] HOLD_M  = 16'(HOLD - 1);
  localparam logic [15:0] GAP_M   = 16'(GAP - 1);
  localparam logic [15:0] QUIET_M = 16'(QUIET - 1);
  localparam logic [15:0] PULSO_M = 16'(PULSO_INI - 1);
  estado_t estado;
  logic [3:0] mem [16];
  logic [3:0] leds_prev, rodada, rodada_nxt;
  logic [4:0] count, ptr, ptr_nxt;
  logic [15:0] timer;
  logic hab_prev, capture, valid, store;
  always_comb begin
    capture    = leds != 4'd0 && leds_prev == 4'd0;
    valid      = (leds & (leds - 4'd1)) == 4'd0;
    store      = estado == OBSERVA && capture && valid && count != 5'd16;
    ptr_nxt    = ptr + 5'd1;
    rodada_nxt = rodada == 4'd15 ? 4'd15 : rodada + 4'd1;
  end
  // The injected round withholds its final press so the game times out
  function automatic logic [3:0] jogada(input logic [3:0] r, input logic [4:0] p);
    return (RODADA_ERRO != 0 && int'(r) == RODADA_ERRO && p == count - 5'd1) ? 4'd0 : mem[p[3:0]];
  endfunction
  always_ff @(posedge clock)
    if (store) mem[count[3:0]] <= leds;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado    <= INICIAL;
      iniciar   <= 1'b0;
      botoes    <= 4'd0;
      erro      <= 1'b0;
      count     <= 5'd0;
      ptr       <= 5'd0;
      rodada    <= 4'd0;
      timer     <= 16'd0;
      leds_prev <= 4'd0;
      hab_prev  <= 1'b0;
    end else begin
      leds_prev <= leds;
      hab_prev  <= habilitar;
      if (estado != FIM && !habilitar) begin
        estado  <= INICIAL;
        iniciar <= 1'b0;
        botoes  <= 4'd0;
        count   <= 5'd0;
        timer   <= 16'd0;
      end else if (estado inside {PULSO, OBSERVA, PRESSIONA, SOLTA} && (ganhou || perdeu)) begin
        estado  <= FIM;
        iniciar <= 1'b0;
        botoes  <= 4'd0;
      end else begin
        case (estado)
          INICIAL: if (!hab_prev) begin
            estado  <= PULSO;
            iniciar <= 1'b1;
            timer   <= 16'd0;
          end
          PULSO: if (timer == PULSO_M) begin
            estado  <= OBSERVA;
            iniciar <= 1'b0;
            count   <= 5'd0;
            rodada  <= 4'd0;
            timer   <= 16'd0;
          end else timer <= timer + 16'd1;
          OBSERVA: begin
            if (capture && (!valid || count == 5'd16)) erro <= 1'b1;
            if (store) count <= count + 5'd1;
            if (leds != 4'd0) timer <= 16'd0;
            else if (count != 5'd0) begin
              if (timer == QUIET_M) begin
                estado <= PRESSIONA;
                ptr    <= 5'd0;
                rodada <= rodada_nxt;
                timer  <= 16'd0;
                botoes <= jogada(rodada_nxt, 5'd0);
              end else timer <= timer + 16'd1;
            end
          end
          PRESSIONA: if (timer == HOLD_M) begin
            estado <= SOLTA;
            botoes <= 4'd0;
            timer  <= 16'd0;
          end else timer <= timer + 16'd1;
          SOLTA: if (timer == GAP_M) begin
            timer <= 16'd0;
            ptr   <= ptr_nxt;
            if (ptr_nxt == count) begin
              estado <= OBSERVA;
              count  <= 5'd0;
            end else begin
              estado <= PRESSIONA;
              botoes <= jogada(rodada, ptr_nxt);
            end
          end else timer <= timer + 16'd1;
          FIM: if (!habilitar) estado <= INICIAL;
          default: estado <= INICIAL;
        endcase
      end
    end
  end
  assign db_estado   = estado;
  assign db_contagem = count;
endmodule

// File: tb/tb_jogador_automatico.sv
// tb_jogador_automatico: directed scenarios for the automatic player with short timing parameters
module tb_jogador_automatico;
  logic clock = 1'b0, reset = 1'b1, habilitar = 1'b0, ganhou = 1'b0, perdeu = 1'b0;
  logic [3:0] leds = 4'd0;
  logic iniciar, erro;
  logic [3:0] botoes, db_estado;
  logic [4:0] db_contagem;
  int errors = 0, checks = 0;
  always #5 clock = ~clock;
  jogador_automatico #(.HOLD(4), .GAP(4), .QUIET(20), .PULSO_INI(5), .RODADA_ERRO(3)) dut (
    .clock(clock), .reset(reset), .habilitar(habilitar), .leds(leds), .ganhou(ganhou),
    .perdeu(perdeu), .iniciar(iniciar), .botoes(botoes), .erro(erro),
    .db_estado(db_estado), .db_contagem(db_contagem));
  task automatic tick();
    @(negedge clock);
  endtask
  task automatic pulse(input logic [3:0] v);
    leds = v;
    tick();
    leds = 4'd0;
    tick();
  endtask
  task automatic start_game();
    int w;
    reset = 1'b1; habilitar = 1'b0; leds = 4'd0; ganhou = 1'b0; perdeu = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    habilitar = 1'b1;
    w = 0;
    while (db_estado !== 4'd2 && w < 20) begin tick(); w++; end
    if (db_estado !== 4'd2) begin
      checks++; errors++;
      $display("FAIL start_timeout: db_estado=%0d required 2", db_estado);
    end
  endtask
  task automatic wait_state(input logic [3:0] s, input string name);
    int w = 0;
    while (db_estado !== s && w < 60) begin tick(); w++; end
    checks++;
    if (db_estado !== s) begin errors++; $display("FAIL %s_timeout: db_estado=%0d required %0d", name, db_estado, s); end
  endtask
  task automatic play_round(input int n, input logic inj, input string name);
    int w = 0;
    logic [3:0] v, e;
    for (int i = 0; i < n; i++) pulse(4'b0001 << (i % 4));
    checks++;
    if (db_contagem !== 5'(n)) begin errors++; $display("FAIL %s_count: got %0d required %0d", name, db_contagem, n); end
    while (db_estado !== 4'd3 && w < 50) begin tick(); w++; end
    checks++;
    if (w != 19) begin errors++; $display("FAIL %s_quiet: replay after %0d cycles required 19", name, w); end
    for (int s = 0; s < n; s++) begin
      v = 4'b0001 << (s % 4);
      for (int k = 0; k < 8; k++) begin
        e = (k < 4 && !(inj && s == n - 1)) ? v : 4'd0;
        checks++;
        if (botoes !== e) begin errors++; $display("FAIL %s_botoes slot %0d cycle %0d: got %b required %b", name, s, k, botoes, e); end
        tick();
      end
    end
    checks++;
    if (db_estado !== 4'd2 || db_contagem !== 5'd0) begin
      errors++; $display("FAIL %s_end: estado=%0d contagem=%0d required 2 and 0", name, db_estado, db_contagem);
    end
  endtask
  task automatic test_reset();
    #1;
    checks++;
    if ({iniciar, botoes, erro, db_estado, db_contagem} !== 15'd0) begin
      errors++; $display("FAIL reset: iniciar=%b botoes=%b erro=%b estado=%0d contagem=%0d required all 0", iniciar, botoes, erro, db_estado, db_contagem);
    end
  endtask
  task automatic test_start();
    int n = 0;
    tick();
    reset = 1'b0;
    tick();
    tick();
    habilitar = 1'b1;
    tick();
    while (iniciar === 1'b1 && n < 20) begin
      checks++;
      if (db_estado !== 4'd1) begin errors++; $display("FAIL start_pulso_state: got %0d required 1", db_estado); end
      n++;
      tick();
    end
    checks++;
    if (n != 5) begin errors++; $display("FAIL start_iniciar_len: got %0d required 5", n); end
    checks++;
    if (db_estado !== 4'd2) begin errors++; $display("FAIL start_observa: got %0d required 2", db_estado); end
  endtask
  task automatic test_replay();
    start_game();
    play_round(3, 1'b0, "replay");
  endtask
  task automatic test_injection();
    start_game();
    play_round(1, 1'b0, "inj_r1");
    play_round(2, 1'b0, "inj_r2");
    play_round(3, 1'b1, "inj_r3");
  endtask
  task automatic test_errors();
    start_game();
    for (int i = 0; i < 16; i++) pulse(4'b0001 << (i % 4));
    checks++;
    if (db_contagem !== 5'd16 || erro !== 1'b0) begin errors++; $display("FAIL full16: contagem=%0d erro=%b required 16 and 0", db_contagem, erro); end
    pulse(4'b0001);
    checks++;
    if (db_contagem !== 5'd16 || erro !== 1'b1) begin errors++; $display("FAIL overflow: contagem=%0d erro=%b required 16 and 1", db_contagem, erro); end
    start_game();
    pulse(4'b0001);
    checks++;
    if (erro !== 1'b0) begin errors++; $display("FAIL erro_cleared: got %b required 0", erro); end
    pulse(4'b0011);
    checks++;
    if (db_contagem !== 5'd1 || erro !== 1'b1) begin errors++; $display("FAIL invalid: contagem=%0d erro=%b required 1 and 1", db_contagem, erro); end
  endtask
  task automatic test_termination();
    start_game();
    pulse(4'b0001);
    pulse(4'b0010);
    wait_state(4'd3, "term_press");
    tick();
    perdeu = 1'b1;
    tick();
    perdeu = 1'b0;
    checks++;
    if (botoes !== 4'd0 || db_estado !== 4'd6) begin errors++; $display("FAIL perdeu: botoes=%b estado=%0d required 0000 and 6", botoes, db_estado); end
    tick();
    checks++;
    if (db_estado !== 4'd6) begin errors++; $display("FAIL fim_hold: got %0d required 6", db_estado); end
    habilitar = 1'b0;
    tick();
    checks++;
    if (db_estado !== 4'd0) begin errors++; $display("FAIL fim_exit: got %0d required 0", db_estado); end
  endtask
  task automatic test_disable();
    start_game();
    pulse(4'b0100);
    checks++;
    if (db_contagem !== 5'd1) begin errors++; $display("FAIL disable_pre: got %0d required 1", db_contagem); end
    habilitar = 1'b0;
    tick();
    checks++;
    if (db_estado !== 4'd0 || db_contagem !== 5'd0) begin errors++; $display("FAIL disable: estado=%0d contagem=%0d required 0 and 0", db_estado, db_contagem); end
  endtask
  task automatic test_reset_mid();
    start_game();
    pulse(4'b0001);
    pulse(4'b1000);
    wait_state(4'd4, "mid_solta");
    checks++;
    if (db_contagem !== 5'd2) begin errors++; $display("FAIL mid_pre: got %0d required 2", db_contagem); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (botoes !== 4'd0 || db_estado !== 4'd0 || db_contagem !== 5'd0 || iniciar !== 1'b0) begin
      errors++; $display("FAIL mid_reset: botoes=%b estado=%0d contagem=%0d iniciar=%b required 0", botoes, db_estado, db_contagem, iniciar);
    end
    tick();
    reset = 1'b0;
  endtask
  initial begin
    test_reset();
    test_start();
    test_replay();
    test_injection();
    test_errors();
    test_termination();
    test_disable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
